// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 frame-capture controller.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        FRAME = 2'd2,
        END   = 2'd3
    } cam_state_t;

    localparam int IMG_W   = 160;
    localparam int IMG_H   = 120;
    localparam int PIX_TOT = IMG_W * IMG_H;

    // RGB565 arrives as {R5,G3hi} then {G3lo,B5}; keep the top bits of each colour.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] b0, input logic [7:0] b1);
        return {b0[7:5], b0[2:0], b1[4:3]};
    endfunction

endpackage

// File: rtl/cam_frame_capture_ctrl_if.sv
// Camera pins, host handshake and frame-buffer write port of the capture controller.
// Optional line_cnt/frame_cnt exist only when FRAME_STATS_EN is defined.
interface cam_frame_capture_ctrl_if #(
    parameter int AW = 15
);
    logic [7:0]    Data;
    logic          Href;
    logic          Vsync;
    logic          start;
    logic          cont;
    logic          stop;
    logic          busy;
    logic          done;
    logic          err;
    logic          regWrite;
    logic [AW-1:0] addr_in;
    logic [7:0]    data_in;

`ifdef FRAME_STATS_EN
    logic [7:0]    line_cnt;
    logic [15:0]   frame_cnt;

    modport master (
        output Data, Href, Vsync, start, cont, stop,
        input  busy, done, err, regWrite, addr_in, data_in, line_cnt, frame_cnt
    );
    modport slave (
        input  Data, Href, Vsync, start, cont, stop,
        output busy, done, err, regWrite, addr_in, data_in, line_cnt, frame_cnt
    );
`else
    modport master (
        output Data, Href, Vsync, start, cont, stop,
        input  busy, done, err, regWrite, addr_in, data_in
    );
    modport slave (
        input  Data, Href, Vsync, start, cont, stop,
        output busy, done, err, regWrite, addr_in, data_in
    );
`endif

endinterface

// File: rtl/cam_sync_edge.sv
// Registers Vsync/Href once and derives frame-start, frame-end and line-end pulses.
// Latency: pulses are combinational against the one-cycle-delayed copies.
// Backpressure: none; camera timing is free-running.
module cam_sync_edge (
    input  logic Pclk,
    input  logic rst,
    input  logic Vsync,
    input  logic Href,
    output logic sof,
    output logic eof,
    output logic line_end,
    output logic href_q
);

    logic vs_q;
    logic hr_q;

    always_ff @(posedge Pclk) begin
        if (rst) begin
            vs_q <= 1'b0;
            hr_q <= 1'b0;
        end else begin
            vs_q <= Vsync;
            hr_q <= Href;
        end
    end

    assign sof      = vs_q & ~Vsync;
    assign eof      = ~vs_q & Vsync;
    assign line_end = hr_q & ~Href;
    assign href_q   = hr_q;

endmodule

// File: rtl/cam_frame_capture_ctrl.sv
// Arms on host start, captures one (or continuous) OV7670 frame as RGB332; FRAME_STATS_EN adds line/frame counters.
// Latency: buffer write strobe 1 Pclk after the second byte of each pixel.
// Backpressure: none; the camera cannot stall, so excess bytes are dropped and flagged in err.
module cam_frame_capture_ctrl #(
    parameter int AW    = 15,
    parameter int IMG_W = cam_pkg::IMG_W,
    parameter int IMG_H = cam_pkg::IMG_H
) (
    input  logic                     Pclk,
    input  logic                     rst,
    cam_frame_capture_ctrl_if.slave  bus
);
    import cam_pkg::*;

    localparam int            XW     = $clog2(IMG_W + 1);
    localparam logic [XW-1:0] X_FULL = XW'(IMG_W);
    localparam logic [7:0]    Y_FULL = 8'(IMG_H);
    localparam logic [AW-1:0] A_LAST = AW'(IMG_W * IMG_H - 1);

    cam_state_t    state, state_nxt;
    logic          sof, eof, line_end, href_q;
    logic          busy_c, done_c;
    logic          cont_r, phase, full, err_r, wr_r;
    logic [7:0]    b0, pix_r, y;
    logic [XW-1:0] x;
    logic [AW-1:0] addr, addr_r;
    logic          line_close, overflow;

    cam_sync_edge u_sync (
        .Pclk     (Pclk),
        .rst      (rst),
        .Vsync    (bus.Vsync),
        .Href     (bus.Href),
        .sof      (sof),
        .eof      (eof),
        .line_end (line_end),
        .href_q   (href_q)
    );

    // A frame ending while Href is still high closes the open line as if Href fell.
    assign line_close = line_end | (eof & href_q);
    assign overflow   = (x == X_FULL) | full;

    always_ff @(posedge Pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = ARM;
            ARM: begin
                busy_c = 1'b1;
                if (bus.stop)  state_nxt = IDLE;
                else if (sof)  state_nxt = FRAME;
            end
            FRAME: begin
                busy_c = 1'b1;
                if (eof) state_nxt = END;
            end
            END: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = (cont_r && !bus.stop) ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            cont_r <= 1'b0;
            phase  <= 1'b0;
            full   <= 1'b0;
            err_r  <= 1'b0;
            wr_r   <= 1'b0;
            b0     <= '0;
            pix_r  <= '0;
            y      <= '0;
            x      <= '0;
            addr   <= '0;
            addr_r <= '0;
        end else begin
            wr_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cont_r <= bus.cont & ~bus.stop;
                        err_r  <= 1'b0;
                    end
                end
                ARM: begin
                    if (!bus.stop && sof) begin
                        addr  <= '0;
                        x     <= '0;
                        y     <= '0;
                        phase <= 1'b0;
                        full  <= 1'b0;
                    end
                end
                FRAME: begin
                    if (bus.stop) cont_r <= 1'b0;
                    if (line_close) begin
                        if (x != X_FULL || phase) err_r <= 1'b1;
                        x     <= '0;
                        phase <= 1'b0;
                        y     <= (y == 8'hFF) ? y : y + 8'd1;
                    end else if (bus.Href && !eof) begin
                        if (phase) begin
                            wr_r   <= 1'b1;
                            pix_r  <= rgb565_to_rgb332(b0, bus.Data);
                            addr_r <= addr;
                            x      <= x + XW'(1);
                            phase  <= 1'b0;
                            // Park on the last address instead of wrapping over the frame start.
                            if (addr == A_LAST) full <= 1'b1;
                            else                addr <= addr + AW'(1);
                        end else if (overflow) begin
                            err_r <= 1'b1;
                        end else begin
                            b0    <= bus.Data;
                            phase <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (y != Y_FULL) err_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.err      = err_r;
    assign bus.regWrite = wr_r;
    assign bus.addr_in  = addr_r;
    assign bus.data_in  = pix_r;

`ifdef FRAME_STATS_EN
    logic [7:0]  line_cnt_r;
    logic [15:0] frame_cnt_r;

    always_ff @(posedge Pclk) begin
        if (rst) begin
            line_cnt_r  <= '0;
            frame_cnt_r <= '0;
        end else if (state == END) begin
            line_cnt_r  <= y;
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign bus.line_cnt  = line_cnt_r;
    assign bus.frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_cam_frame_capture_ctrl.sv
// Randomized camera-frame stimulus with a queue scoreboard for buffer writes and done/err.
module tb_cam_frame_capture_ctrl;
    localparam int AW      = 15;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 3;
    localparam int PIX_TOT = IMG_W * IMG_H;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    pix;
    } wr_t;

    logic Pclk = 1'b0;
    logic rst;
    always #5 Pclk = ~Pclk;

    cam_frame_capture_ctrl_if #(.AW(AW)) bus ();

    cam_frame_capture_ctrl #(.AW(AW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .Pclk (Pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    wr_t  wr_q[$];
    bit   done_q[$];
    bit   sticky_err = 1'b0;
    bit   err_pending = 1'b0;
    bit   err_exp_hold = 1'b0;
    bit   directed = 1'b0;
    wr_t  mon_e;
    logic [7:0] fb [8][16];
    int   flen [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
        int r = int'(hi) / 32;
        int g = int'(hi) % 8;
        int b = (int'(lo) / 8) % 4;
        return 8'(r * 32 + g * 4 + b);
    endfunction

    // Monitor: every write and every done must match something the model predicted.
    always @(negedge Pclk) begin
        if (err_pending) begin
            check("err_after_done", 32'(bus.err), 32'(err_exp_hold));
            err_pending = 1'b0;
        end
        if (bus.regWrite) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         bus.addr_in, bus.data_in);
            end else begin
                mon_e = wr_q.pop_front();
                check("wr_addr", 32'(bus.addr_in), 32'(mon_e.addr));
                check("wr_data", 32'(bus.data_in), 32'(mon_e.pix));
            end
        end
        if (bus.done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1, no frame completion expected");
            end else begin
                err_exp_hold = done_q.pop_front();
                err_pending  = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge Pclk);
    endtask

    task automatic fill(input int nl);
        for (int i = 0; i < nl; i++)
            for (int k = 0; k < flen[i]; k++)
                fb[i][k] = 8'($urandom);
        if (directed) begin
            fb[0][0] = 8'hE7; fb[0][1] = 8'h18;
            fb[0][2] = 8'h00; fb[0][3] = 8'h00;
        end
    endtask

    // Reference: pixel k of a line lands in the buffer if k < IMG_W and the buffer is not full;
    // a frame is in error unless every line carries exactly 2*IMG_W bytes and there are IMG_H lines.
    task automatic model_frame(input int nl, input bit push_done);
        int  w = 0;
        bit  ferr = 1'b0;
        wr_t e;
        for (int i = 0; i < nl; i++) begin
            if (flen[i] != 2 * IMG_W) ferr = 1'b1;
            for (int k = 0; k < flen[i] / 2; k++) begin
                if (k < IMG_W && w < PIX_TOT) begin
                    e.addr = AW'(w);
                    e.pix  = rgb332(fb[i][2*k], fb[i][2*k+1]);
                    wr_q.push_back(e);
                    w++;
                end
            end
        end
        if (nl != IMG_H) ferr = 1'b1;
        sticky_err = sticky_err | ferr;
        if (push_done) done_q.push_back(sticky_err);
    endtask

    task automatic drive_frame(input int nl, input bit vs_hi, input int stop_line);
        bus.Vsync = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < nl; i++) begin
            for (int k = 0; k < flen[i]; k++) begin
                bus.Href = 1'b1;
                bus.Data = fb[i][k];
                bus.stop = (i == stop_line && k == 0);
                tick();
            end
            bus.stop = 1'b0;
            if (i == nl - 1 && vs_hi) begin
                bus.Vsync = 1'b1;
                bus.Data  = 8'($urandom);
                tick();
                bus.Href = 1'b0;
            end else begin
                bus.Href = 1'b0;
                repeat (2) tick();
            end
        end
        if (!vs_hi) begin
            bus.Vsync = 1'b1;
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic send(input int nl, input bit capture, input bit vs_hi, input int stop_line);
        fill(nl);
        if (capture) model_frame(nl, 1'b1);
        drive_frame(nl, vs_hi, stop_line);
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d);
        flen[0] = a; flen[1] = b; flen[2] = c; flen[3] = d;
    endtask

    task automatic start_cap(input bit c, input bit s);
        bus.start = 1'b1;
        bus.cont  = c;
        bus.stop  = s;
        tick();
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        sticky_err = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.Data  = '0;
        bus.Href  = 1'b0;
        bus.Vsync = 1'b1;
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        bus.stop  = 1'b0;
        repeat (3) tick();
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_err",      32'(bus.err),      32'd0);
        check("rst_regWrite", 32'(bus.regWrite), 32'd0);
        check("rst_addr_in",  32'(bus.addr_in),  32'd0);
        check("rst_data_in",  32'(bus.data_in),  32'd0);
        rst = 1'b0;
        tick();

        // Single frame with directed packing pixels, then an ignored frame.
        start_cap(1'b0, 1'b0);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        set_lens(8, 8, 8, 8);
        directed = 1'b1;
        send(3, 1'b1, 1'b0, -1);
        directed = 1'b0;
        wait_idle("busy_single");
        send(3, 1'b0, 1'b0, -1);

        // Arm in the middle of a frame: nothing written until the next frame start.
        bus.Vsync = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 8; k++) begin
                bus.Href = 1'b1;
                bus.Data = 8'($urandom);
                tick();
            end
            bus.Href = 1'b0;
            if (l == 1) start_cap(1'b0, 1'b0);
            else        repeat (2) tick();
        end
        bus.Vsync = 1'b1;
        repeat (3) tick();
        check("busy_armed", 32'(bus.busy), 32'd1);
        set_lens(8, 8, 8, 8);
        send(3, 1'b1, 1'b1, -1);
        wait_idle("busy_midarm");

        // Short line sets sticky err; the next start clears it.
        start_cap(1'b0, 1'b0);
        set_lens(8, 6, 8, 8);
        send(3, 1'b1, 1'b0, -1);
        wait_idle("busy_short");
        start_cap(1'b0, 1'b0);
        check("err_cleared_by_start", 32'(bus.err), 32'd0);
        set_lens(8, 8, 8, 8);
        send(3, 1'b1, 1'b0, -1);
        wait_idle("busy_after_clear");

        // Continuous capture, stop during the third frame.
        start_cap(1'b1, 1'b0);
        send(3, 1'b1, 1'b0, -1);
        check("busy_cont", 32'(bus.busy), 32'd1);
        send(3, 1'b1, 1'b0, -1);
        send(3, 1'b1, 1'b0, 1);
        wait_idle("busy_cont_stop");
        send(3, 1'b0, 1'b0, -1);

        // Stop while armed returns to idle at once.
        start_cap(1'b0, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("busy_stop_arm", 32'(bus.busy), 32'd0);
        send(3, 1'b0, 1'b0, -1);

        // Start and stop together with cont=1 behaves as a single capture.
        start_cap(1'b1, 1'b1);
        send(3, 1'b1, 1'b0, -1);
        wait_idle("busy_start_stop");
        send(3, 1'b0, 1'b0, -1);

        // Randomized frame shapes: line lengths, line counts and Vsync/Href overlap.
        for (int f = 0; f < 8; f++) begin
            int nl;
            int lens_pick [6] = '{6, 7, 8, 8, 9, 10};
            nl = $urandom_range(2, 4);
            for (int i = 0; i < nl; i++) flen[i] = lens_pick[$urandom_range(0, 5)];
            start_cap(1'b0, 1'b0);
            send(nl, 1'b1, 1'($urandom_range(0, 1)), -1);
            wait_idle("busy_random");
        end

        // Reset in the middle of a frame.
        start_cap(1'b0, 1'b0);
        bus.Vsync = 1'b0;
        repeat (3) tick();
        flen[0] = 8;
        fill(1);
        model_frame(1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            bus.Href = 1'b1;
            bus.Data = fb[0][k];
            tick();
        end
        bus.Href = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy",     32'(bus.busy),     32'd0);
        check("midrst_regWrite", 32'(bus.regWrite), 32'd0);
        check("midrst_addr_in",  32'(bus.addr_in),  32'd0);
        check("midrst_done",     32'(bus.done),     32'd0);
        rst = 1'b0;
        sticky_err = 1'b0;
        bus.Vsync = 1'b1;
        repeat (8) tick();

        check("wr_queue_drained",   32'(wr_q.size()),   32'd0);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
